// File: rtl/sensor_sched_pkg.sv
// rtl/sensor_sched_pkg.sv - shared types, defaults and helpers for the sensor measurement scheduler
package sensor_sched_pkg;

  typedef enum logic [2:0] {IDLE, ARB, START, WAIT, GUARD} sched_state_e;

  localparam int DEF_NUM_REQ       = 2;
  localparam int DEF_PERIOD_TICKS  = 10;
  localparam int DEF_TIMEOUT_TICKS = 3;
  localparam int DEF_GUARD_TICKS   = 6;

  // Width of a channel index; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_meas_sched_rr_arbiter.sv
// rtl/sensor_meas_sched_rr_arbiter.sv - combinational round-robin pick over pending channels
module rr_arbiter
  import sensor_sched_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      grant,
  output logic               valid
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest pending channel after last_grant wins
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (pend[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_meas_sched.sv
// rtl/sensor_meas_sched.sv - shares one sensor measurement slot among NUM_REQ drivers
module sensor_meas_sched
  import sensor_sched_pkg::*;
#(
  parameter int  NUM_REQ       = DEF_NUM_REQ,
  parameter int  PERIOD_TICKS  = DEF_PERIOD_TICKS,
  parameter int  TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int  GUARD_TICKS   = DEF_GUARD_TICKS,
  localparam int IW            = idx_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick_in,
  input  logic                       auto_en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         start,
  output logic                       active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] timeout_id
);

  localparam int PW = $clog2(PERIOD_TICKS) + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS) + 1;
  localparam int GW = $clog2(GUARD_TICKS) + 1;
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_TICKS - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [GW-1:0] GUARD_LAST   = GW'((GUARD_TICKS > 0) ? GUARD_TICKS - 1 : 0);

  sched_state_e        state, state_n;
  logic                tick_d, tick_rise;
  logic [PW-1:0]       period_cnt;
  logic                period_wrap;
  logic [NUM_REQ-1:0]  pend, pend_set, pend_clr, grant_onehot;
  logic [IW-1:0]       last_grant, arb_grant;
  logic                arb_valid;
  logic [TW-1:0]       wait_cnt;
  logic [GW-1:0]       guard_cnt;
  logic                timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .pend       (pend),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign tick_rise   = tick_in & ~tick_d;
  assign period_wrap = auto_en & tick_rise & (period_cnt == PERIOD_LAST);

  // Tick edge detect and auto-mode period counter, held at zero while auto mode is off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_d     <= 1'b0;
      period_cnt <= '0;
    end else begin
      tick_d <= tick_in;
      if (!auto_en)
        period_cnt <= '0;
      else if (tick_rise)
        period_cnt <= period_wrap ? '0 : period_cnt + 1'b1;
    end
  end

  // Pending-bit set/clear sources; a set on the same bit as the clear wins
  always_comb begin
    grant_onehot           = '0;
    grant_onehot[grant_id] = 1'b1;
    pend_set               = req | {NUM_REQ{period_wrap}};
    pend_clr               = (state == START) ? grant_onehot : '0;
  end

  // Pending bits merge repeated requests for a channel into one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~pend_clr) | pend_set;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next state and Moore outputs; done from the granted channel beats a coincident final tick
  always_comb begin
    state_n     = state;
    start       = '0;
    active      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:  if (|pend) state_n = ARB;
      ARB:   state_n = arb_valid ? START : IDLE;
      START: begin
        start   = grant_onehot;
        active  = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        active = 1'b1;
        if (done[grant_id]) begin
          state_n = GUARD;
        end else if (tick_rise && wait_cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_n     = GUARD;
        end
      end
      GUARD: begin
        if (GUARD_TICKS == 0)
          state_n = IDLE;
        else if (tick_rise && guard_cnt == GUARD_LAST)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant bookkeeping, WAIT/GUARD tick counters and the registered timeout report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id    <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      wait_cnt    <= '0;
      guard_cnt   <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= '0;
    end else begin
      timeout_err <= timeout_hit;
      if (timeout_hit) timeout_id <= grant_id;
      if (state == ARB && arb_valid) begin
        grant_id   <= arb_grant;
        last_grant <= arb_grant;
      end
      if (state == START)
        wait_cnt <= '0;
      else if (state == WAIT && tick_rise)
        wait_cnt <= wait_cnt + 1'b1;
      if (state != GUARD)
        guard_cnt <= '0;
      else if (tick_rise)
        guard_cnt <= guard_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sensor_meas_sched.sv
// tb/tb_sensor_meas_sched.sv - scoreboard bench for sensor_meas_sched
module tb_sensor_meas_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       auto_en = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  logic [1:0] start;
  logic       active;
  logic [0:0] grant_id;
  logic       timeout_err;
  logic [0:0] timeout_id;

  typedef struct packed {logic [1:0] st; logic gid; int cyc;} start_exp_t;
  typedef struct packed {logic id; int cyc;} to_exp_t;

  start_exp_t exp_start[$];
  to_exp_t    exp_to[$];
  start_exp_t mon_s;
  to_exp_t    mon_t;
  logic [1:0] resp_ch;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  n_start = 0;
  int  req_k = 0;
  int  base = 0;
  bit  resp_en = 1'b0;

  sensor_meas_sched #(
    .NUM_REQ(2), .PERIOD_TICKS(10), .TIMEOUT_TICKS(3), .GUARD_TICKS(6)
  ) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .auto_en(auto_en),
    .req(req), .done(done), .start(start), .active(active),
    .grant_id(grant_id), .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // start monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (start !== 2'b00) begin
      n_start++;
      if (exp_start.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL start_unexpected: got start=%b required none (cycle %0d)", start, cyc);
      end else begin
        mon_s = exp_start.pop_front();
        chk("start_vec", int'(start), int'(mon_s.st));
        chk("start_gid", int'(grant_id), int'(mon_s.gid));
        if (mon_s.cyc >= 0) chk("start_cycle", cyc, mon_s.cyc);
      end
    end
    if (timeout_err !== 1'b0) begin
      if (exp_to.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL timeout_unexpected: got timeout_err=%b required 0 (cycle %0d)", timeout_err, cyc);
      end else begin
        mon_t = exp_to.pop_front();
        chk("timeout_id", int'(timeout_id), int'(mon_t.id));
        chk("timeout_cycle", cyc, mon_t.cyc);
      end
    end
  end

  // optional driver model: done returned 5 cycles after each start
  initial forever begin
    @(negedge clk);
    if (resp_en && start != 2'b00) begin
      resp_ch = start;
      repeat (5) @(negedge clk);
      done = resp_ch;
      @(negedge clk);
      done = 2'b00;
    end
  end

  // kind: 0 none, 1 start expected 3 cycles after the rise, 2 timeout expected 1 cycle after
  task automatic do_tick(input int kind, input logic [1:0] st, input logic gid);
    @(negedge clk);
    tick_in = 1'b1;
    if (kind == 1) exp_start.push_back('{st: st, gid: gid, cyc: cyc + 3});
    if (kind == 2) exp_to.push_back('{id: gid, cyc: cyc + 1});
    repeat (11) @(negedge clk);
    tick_in = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(0, 2'b00, 1'b0);
  endtask

  task automatic do_req(input logic [1:0] v);
    @(negedge clk);
    req   = v;
    req_k = cyc;
    @(negedge clk);
    req = 2'b00;
  endtask

  task automatic pulse_done(input logic [1:0] v);
    @(negedge clk);
    done = v;
    @(negedge clk);
    done = 2'b00;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int t;
    t = 0;
    while (n_start < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("start_arrived", (n_start >= target) ? 1 : 0, 1);
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_start", int'(start), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_timeout_id", int'(timeout_id), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single request on ch1: start at N+3, active until done
    do_req(2'b10);
    exp_start.push_back('{st: 2'b10, gid: 1'b1, cyc: req_k + 3});
    wait_starts(1, 20);
    repeat (3) @(negedge clk);
    chk("t1_active_wait", int'(active), 1);
    pulse_done(2'b10);
    chk("t1_active_after_done", int'(active), 0);
    ticks(6);

    // both requested together, guard spacing, round-robin restarts at ch0
    resp_en = 1'b1;
    base = n_start;
    do_req(2'b11);
    exp_start.push_back('{st: 2'b01, gid: 1'b0, cyc: req_k + 3});
    exp_start.push_back('{st: 2'b10, gid: 1'b1, cyc: -1});
    wait_starts(base + 1, 20);
    repeat (10) @(negedge clk);
    ticks(5);
    chk("t3_guard_holds", n_start, base + 1);
    do_tick(0, 2'b00, 1'b0);
    wait_starts(base + 2, 20);
    repeat (10) @(negedge clk);
    ticks(6);
    do_req(2'b11);
    exp_start.push_back('{st: 2'b01, gid: 1'b0, cyc: req_k + 3});
    exp_start.push_back('{st: 2'b10, gid: 1'b1, cyc: -1});
    wait_starts(base + 3, 20);
    repeat (10) @(negedge clk);
    ticks(6);
    wait_starts(base + 4, 20);
    repeat (10) @(negedge clk);
    ticks(6);
    resp_en = 1'b0;

    // timeout on ch0 at the third tick rise
    base = n_start;
    do_req(2'b01);
    exp_start.push_back('{st: 2'b01, gid: 1'b0, cyc: req_k + 3});
    wait_starts(base + 1, 20);
    ticks(2);
    chk("to_still_active", int'(active), 1);
    do_tick(2, 2'b00, 1'b0);
    chk("to_in_guard", int'(active), 0);
    ticks(6);

    // done coincides with the third tick rise: no error
    base = n_start;
    do_req(2'b01);
    exp_start.push_back('{st: 2'b01, gid: 1'b0, cyc: req_k + 3});
    wait_starts(base + 1, 20);
    ticks(2);
    @(negedge clk);
    tick_in = 1'b1;
    done    = 2'b01;
    @(negedge clk);
    done = 2'b00;
    chk("race_done_wins", int'(active), 0);
    repeat (10) @(negedge clk);
    tick_in = 1'b0;
    repeat (8) @(negedge clk);
    ticks(6);

    // done from the non-granted channel is ignored
    base = n_start;
    do_req(2'b01);
    exp_start.push_back('{st: 2'b01, gid: 1'b0, cyc: req_k + 3});
    wait_starts(base + 1, 20);
    pulse_done(2'b10);
    repeat (2) @(negedge clk);
    chk("foreign_done_ignored", int'(active), 1);
    pulse_done(2'b01);
    chk("own_done_ends", int'(active), 0);
    ticks(6);

    // auto mode: wrap once per 10 rises with 11-cycle-wide ticks
    base = n_start;
    auto_en = 1'b1;
    ticks(9);
    chk("auto_no_early_wrap", n_start, base);
    do_tick(1, 2'b10, 1'b1);
    chk("auto_first_start", n_start, base + 1);
    auto_en = 1'b0;
    chk("auto_off_mid_meas", int'(active), 1);
    pulse_done(2'b10);
    ticks(5);
    do_tick(1, 2'b01, 1'b0);
    pulse_done(2'b01);
    ticks(6);
    ticks(12);
    chk("auto_off_no_start", n_start, base + 2);
    auto_en = 1'b1;
    ticks(9);
    chk("auto_restart_no_early", n_start, base + 2);
    do_tick(1, 2'b10, 1'b1);
    pulse_done(2'b10);
    ticks(5);
    do_tick(1, 2'b01, 1'b0);
    auto_en = 1'b0;
    pulse_done(2'b01);
    ticks(6);

    // async reset mid-WAIT with ch1 pending: nothing replayed afterwards
    base = n_start;
    do_req(2'b01);
    exp_start.push_back('{st: 2'b01, gid: 1'b0, cyc: req_k + 3});
    wait_starts(base + 1, 20);
    do_req(2'b10);
    repeat (2) @(negedge clk);
    chk("pre_rst_pend", int'(dut.pend), 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_active", int'(active), 0);
    chk("rst_async_pend", int'(dut.pend), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = n_start;
    repeat (30) @(negedge clk);
    chk("no_replay_after_rst", n_start, base);
    do_req(2'b01);
    exp_start.push_back('{st: 2'b01, gid: 1'b0, cyc: req_k + 3});
    wait_starts(base + 1, 20);
    pulse_done(2'b01);
    repeat (5) @(negedge clk);

    chk("start_queue_drained", exp_start.size(), 0);
    chk("timeout_queue_drained", exp_to.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
